// File: rtl/avalon_burst_splitter.sv
// rtl/avalon_burst_splitter.sv - splits Avalon-MM bursts into single-beat 128-bit transactions
//
// Purpose:
//   Accepts bursting reads/writes on the slave side and issues single-beat
//   transactions with an incrementing word address toward the 128->512 upsizer.
//   The downstream path has a fixed read latency and no readdatavalid, so
//   s_readdatavalid is regenerated from a READ_LATENCY-deep pipe of accepts.
//
// Optional feature (macro AVALON_BURST_SPLITTER_PERF_EN):
//   Adds saturating counters perf_rd_beats, perf_wr_beats, perf_stall.
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   s_addr, s_read, s_write   upstream command (burst start address)
//   s_burstcount              burst length, sampled on the first beat (0 means 1)
//   s_byteenable, s_writedata per-beat write byte enables and data
//   s_readdata, s_readdatavalid, s_waitrequest   upstream responses/stall
//   m_addr, m_read, m_write   single-beat command to upsizer
//   m_byteenable, m_writedata write byte enables and data to upsizer
//   m_readdata, m_waitrequest read data and stall from upsizer
//   perf_rd_beats, perf_wr_beats, perf_stall     (optional) performance counters

module avalon_burst_splitter #(
    parameter int ADDR_W       = 15,
    parameter int BURST_W      = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [ADDR_W-1:0]   s_addr,
    input  logic                s_read,
    input  logic                s_write,
    input  logic [BURST_W-1:0]  s_burstcount,
    input  logic [15:0]         s_byteenable,
    input  logic [127:0]        s_writedata,
    output logic [127:0]        s_readdata,
    output logic                s_readdatavalid,
    output logic                s_waitrequest,
    output logic [ADDR_W-1:0]   m_addr,
    output logic                m_read,
    output logic                m_write,
    output logic [15:0]         m_byteenable,
    output logic [127:0]        m_writedata,
    input  logic [127:0]        m_readdata,
    input  logic                m_waitrequest
`ifdef AVALON_BURST_SPLITTER_PERF_EN
    ,
    output logic [31:0]         perf_rd_beats,
    output logic [31:0]         perf_wr_beats,
    output logic [31:0]         perf_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [BURST_W-1:0]      beat_cnt, beat_cnt_nxt;
    logic [ADDR_W-1:0]       addr_reg, addr_reg_nxt;
    logic [BURST_W-1:0]      burst_eff;
    logic [READ_LATENCY-1:0] rd_pipe;
    logic                    rd_acc;
    logic                    wr_acc;

    assign burst_eff = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;

    // beat_cnt holds the beats still to be issued, so the last beat is the
    // one accepted while beat_cnt == 1.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            beat_cnt <= '0;
            addr_reg <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            addr_reg <= addr_reg_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        beat_cnt_nxt  = beat_cnt;
        addr_reg_nxt  = addr_reg;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_addr        = addr_reg;
        m_byteenable  = s_byteenable;
        m_writedata   = s_writedata;
        s_waitrequest = 1'b1;

        case (state)
            IDLE: begin
                if (s_write) begin
                    // Write wins over a simultaneous read; first beat goes
                    // straight through without a register stage.
                    m_write       = 1'b1;
                    m_addr        = s_addr;
                    s_waitrequest = m_waitrequest;
                    if (!m_waitrequest && burst_eff != BURST_W'(1)) begin
                        state_nxt    = WR_BURST;
                        beat_cnt_nxt = burst_eff - BURST_W'(1);
                        addr_reg_nxt = s_addr + ADDR_W'(1);
                    end
                end else if (s_read) begin
                    s_waitrequest = 1'b0;
                    state_nxt     = RD_BURST;
                    beat_cnt_nxt  = burst_eff;
                    addr_reg_nxt  = s_addr;
                end else begin
                    s_waitrequest = 1'b0;
                end
            end
            RD_BURST: begin
                m_read = 1'b1;
                if (!m_waitrequest) begin
                    addr_reg_nxt = addr_reg + ADDR_W'(1);
                    beat_cnt_nxt = beat_cnt - BURST_W'(1);
                    if (beat_cnt == BURST_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            WR_BURST: begin
                m_write       = s_write;
                s_waitrequest = m_waitrequest;
                if (s_write && !m_waitrequest) begin
                    addr_reg_nxt = addr_reg + ADDR_W'(1);
                    beat_cnt_nxt = beat_cnt - BURST_W'(1);
                    if (beat_cnt == BURST_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Hold the downstream bus quiet and stall upstream while in reset.
        if (!rstn) begin
            m_read        = 1'b0;
            m_write       = 1'b0;
            s_waitrequest = 1'b1;
        end
    end

    assign rd_acc = m_read & ~m_waitrequest;
    assign wr_acc = m_write & ~m_waitrequest;

    // One bit per cycle of downstream latency; a 1 marks a read whose data
    // appears on m_readdata when it reaches the last stage.
    generate
        if (READ_LATENCY == 1) begin : g_pipe_one
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    rd_pipe <= '0;
                end else begin
                    rd_pipe <= rd_acc;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    rd_pipe <= '0;
                end else begin
                    rd_pipe <= {rd_pipe[READ_LATENCY-2:0], rd_acc};
                end
            end
        end
    endgenerate

    assign s_readdatavalid = rstn & rd_pipe[READ_LATENCY-1];
    assign s_readdata      = m_readdata;

`ifdef AVALON_BURST_SPLITTER_PERF_EN
    logic stall_cyc;
    assign stall_cyc = (m_read | m_write) & m_waitrequest;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_rd_beats <= '0;
            perf_wr_beats <= '0;
            perf_stall    <= '0;
        end else begin
            if (rd_acc && perf_rd_beats != '1) begin
                perf_rd_beats <= perf_rd_beats + 32'd1;
            end
            if (wr_acc && perf_wr_beats != '1) begin
                perf_wr_beats <= perf_wr_beats + 32'd1;
            end
            if (stall_cyc && perf_stall != '1) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`else
    logic unused_wr_acc;
    assign unused_wr_acc = wr_acc;
`endif

endmodule

// File: tb/tb_avalon_burst_splitter.sv
// tb/tb_avalon_burst_splitter.sv - directed self-checking bench for avalon_burst_splitter

module tb_avalon_burst_splitter;

    logic         clk;
    logic         rstn;
    logic [14:0]  s_addr;
    logic         s_read;
    logic         s_write;
    logic [3:0]   s_burstcount;
    logic [15:0]  s_byteenable;
    logic [127:0] s_writedata;
    logic         m_waitrequest;

    logic [127:0] s_readdata1, s_readdata3;
    logic         s_readdatavalid1, s_readdatavalid3;
    logic         s_waitrequest1, s_waitrequest3;
    logic [14:0]  m_addr1, m_addr3;
    logic         m_read1, m_read3;
    logic         m_write1, m_write3;
    logic [15:0]  m_byteenable1, m_byteenable3;
    logic [127:0] m_writedata1, m_writedata3;
    logic [127:0] m_readdata1, m_readdata3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt1 = 0;
    int rdv_cnt1 = 0;
    int rdv_cnt3 = 0;
    int q1c[$];
    int q3c[$];
    logic [14:0] q1a[$];
    logic [14:0] q3a[$];

    logic [14:0] d1;
    logic [14:0] d3 [3];

    avalon_burst_splitter #(.ADDR_W(15), .BURST_W(4), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .s_addr(s_addr), .s_read(s_read), .s_write(s_write),
        .s_burstcount(s_burstcount), .s_byteenable(s_byteenable), .s_writedata(s_writedata),
        .s_readdata(s_readdata1), .s_readdatavalid(s_readdatavalid1), .s_waitrequest(s_waitrequest1),
        .m_addr(m_addr1), .m_read(m_read1), .m_write(m_write1), .m_byteenable(m_byteenable1),
        .m_writedata(m_writedata1), .m_readdata(m_readdata1), .m_waitrequest(m_waitrequest)
    );

    avalon_burst_splitter #(.ADDR_W(15), .BURST_W(4), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .rstn(rstn), .s_addr(s_addr), .s_read(s_read), .s_write(s_write),
        .s_burstcount(s_burstcount), .s_byteenable(s_byteenable), .s_writedata(s_writedata),
        .s_readdata(s_readdata3), .s_readdatavalid(s_readdatavalid3), .s_waitrequest(s_waitrequest3),
        .m_addr(m_addr3), .m_read(m_read3), .m_write(m_write3), .m_byteenable(m_byteenable3),
        .m_writedata(m_writedata3), .m_readdata(m_readdata3), .m_waitrequest(m_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [127:0] pat(input logic [14:0] a);
        return {8{1'b1, a}};
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Downstream memory model: data for the address accepted L cycles ago.
    always @(posedge clk) begin
        d1    <= m_addr1;
        d3[0] <= m_addr3;
        d3[1] <= d3[0];
        d3[2] <= d3[1];
    end
    assign m_readdata1 = pat(d1);
    assign m_readdata3 = pat(d3[2]);

    // Scoreboard: every accepted read must return exactly L cycles later, in order.
    always @(negedge clk) begin
        if (m_read1 && !m_waitrequest) begin q1c.push_back(cyc); q1a.push_back(m_addr1); end
        if (m_read3 && !m_waitrequest) begin q3c.push_back(cyc); q3a.push_back(m_addr3); end
        if (m_write1 && !m_waitrequest) wr_cnt1++;
        if (s_readdatavalid1) begin
            rdv_cnt1++;
            check_eq("rdv1_pending", 128'(q1c.size() > 0), 128'd1);
            if (q1c.size() > 0) begin
                check_eq("rdv1_latency", 128'(cyc), 128'(q1c.pop_front() + 1));
                check_eq("rdv1_data", s_readdata1, pat(q1a.pop_front()));
            end
        end
        if (s_readdatavalid3) begin
            rdv_cnt3++;
            check_eq("rdv3_pending", 128'(q3c.size() > 0), 128'd1);
            if (q3c.size() > 0) begin
                check_eq("rdv3_latency", 128'(cyc), 128'(q3c.pop_front() + 3));
                check_eq("rdv3_data", s_readdata3, pat(q3a.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] ea;
        int w0, n, r1, r3;

        rstn = 1'b0; s_addr = '0; s_read = 1'b0; s_write = 1'b1; s_burstcount = 4'd1;
        s_byteenable = '0; s_writedata = '0; m_waitrequest = 1'b0;
        tick(); tick();
        #1;
        check_eq("rst_m_write", m_write1, 1'b0);
        check_eq("rst_m_read", m_read1, 1'b0);
        check_eq("rst_s_wait", s_waitrequest1, 1'b1);
        check_eq("rst_rdv", s_readdatavalid1, 1'b0);
        s_write = 1'b0; rstn = 1'b1;
        tick();

        // single write
        s_write = 1'b1; s_addr = 15'h0010; s_burstcount = 4'd1;
        s_byteenable = 16'hFFFF; s_writedata = {16{8'hA5}};
        #1;
        check_eq("w1_m_write", m_write1, 1'b1);
        check_eq("w1_m_addr", m_addr1, 15'h0010);
        check_eq("w1_m_wdata", m_writedata1, {16{8'hA5}});
        check_eq("w1_m_be", m_byteenable1, 16'hFFFF);
        check_eq("w1_s_wait", s_waitrequest1, 1'b0);
        tick();

        // burstcount 0 write is a single beat: next write uses its own s_addr
        s_addr = 15'h0020; s_burstcount = 4'd0; s_byteenable = 16'h00FF; s_writedata = 128'h1234;
        #1;
        check_eq("bc0_m_addr", m_addr1, 15'h0020);
        check_eq("bc0_m_be", m_byteenable1, 16'h00FF);
        tick();
        s_addr = 15'h0030; s_burstcount = 4'd1;
        #1;
        check_eq("bc0_idle_addr", m_addr1, 15'h0030);
        check_eq("bc0_idle_write", m_write1, 1'b1);
        tick();

        // simultaneous read and write in IDLE
        s_read = 1'b1; s_addr = 15'h0040;
        #1;
        check_eq("rw_m_write", m_write1, 1'b1);
        check_eq("rw_m_read", m_read1, 1'b0);
        check_eq("rw_m_addr", m_addr1, 15'h0040);
        tick();
        s_read = 1'b0; s_write = 1'b0;
        #1;
        check_eq("rw_no_rdburst", m_read1, 1'b0);
        check_eq("rw_idle_wait", s_waitrequest1, 1'b0);
        tick();

        // write burst of 4 with a 3-cycle stall on beat 2 and an idle gap
        w0 = wr_cnt1;
        s_write = 1'b1; s_addr = 15'h0100; s_burstcount = 4'd4; s_writedata = 128'hD0;
        #1;
        check_eq("wb_addr0", m_addr1, 15'h0100);
        check_eq("wb_wait0", s_waitrequest1, 1'b0);
        tick();
        s_addr = 15'h0999; s_burstcount = 4'd1; s_writedata = 128'hD1; m_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("wb_stall_addr", m_addr1, 15'h0101);
            check_eq("wb_stall_wait", s_waitrequest1, 1'b1);
            tick();
        end
        m_waitrequest = 1'b0;
        #1;
        check_eq("wb_addr1", m_addr1, 15'h0101);
        check_eq("wb_wait1", s_waitrequest1, 1'b0);
        check_eq("wb_wdata1", m_writedata1, 128'hD1);
        tick();
        s_write = 1'b0;
        #1;
        check_eq("wb_gap", m_write1, 1'b0);
        tick();
        s_write = 1'b1; s_writedata = 128'hD2;
        #1;
        check_eq("wb_addr2", m_addr1, 15'h0102);
        tick();
        s_writedata = 128'hD3;
        #1;
        check_eq("wb_addr3", m_addr1, 15'h0103);
        tick();
        s_addr = 15'h0200;
        #1;
        check_eq("wb_count", 128'(wr_cnt1 - w0), 128'd4);
        check_eq("wb_back_idle", m_addr1, 15'h0200);
        tick();
        s_write = 1'b0;

        // read burst of 8 wrapping the address space, no stalls
        s_read = 1'b1; s_addr = 15'h7FFC; s_burstcount = 4'd8;
        #1;
        check_eq("rb8_cmd_wait", s_waitrequest1, 1'b0);
        check_eq("rb8_cmd_noread", m_read1, 1'b0);
        tick();
        s_read = 1'b0; s_addr = '0;
        for (int i = 0; i < 8; i++) begin
            ea = 15'(32'h7FFC + i);
            #1;
            check_eq("rb8_m_read", m_read1, 1'b1);
            check_eq("rb8_m_addr", m_addr1, ea);
            check_eq("rb8_s_wait", s_waitrequest1, 1'b1);
            tick();
        end

        // read burst of 4 accepted while the previous reads drain, toggling stall
        s_read = 1'b1; s_addr = 15'h0500; s_burstcount = 4'd4;
        #1;
        check_eq("rb4_cmd_wait", s_waitrequest1, 1'b0);
        tick();
        s_read = 1'b0;
        n = 0;
        for (int k = 0; k < 20 && n < 4; k++) begin
            m_waitrequest = k[0];
            #1;
            check_eq("rb4_m_read", m_read3, 1'b1);
            check_eq("rb4_s_wait", s_waitrequest3, 1'b1);
            check_eq("rb4_m_addr", m_addr3, 15'(32'h0500 + n));
            if (!m_waitrequest) n++;
            tick();
        end
        check_eq("rb4_beats", 128'(n), 128'd4);
        m_waitrequest = 1'b0;
        #1;
        check_eq("rb4_done", m_read1, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        check_eq("rd_pulses1", 128'(rdv_cnt1), 128'd12);
        check_eq("rd_pulses3", 128'(rdv_cnt3), 128'd12);
        check_eq("rd_q1_empty", 128'(q1c.size()), 128'd0);
        check_eq("rd_q3_empty", 128'(q3c.size()), 128'd0);

        // reset during beat 3 of an 8-beat read
        s_read = 1'b1; s_addr = 15'h0800; s_burstcount = 4'd8;
        tick();
        s_read = 1'b0;
        #1;
        check_eq("rst_b0", m_addr1, 15'h0800);
        tick();
        #1;
        check_eq("rst_b1", m_addr1, 15'h0801);
        tick();
        rstn = 1'b0;
        #1;
        check_eq("rstmid_m_read", m_read1, 1'b0);
        check_eq("rstmid_rdv1", s_readdatavalid1, 1'b0);
        check_eq("rstmid_wait", s_waitrequest1, 1'b1);
        tick();
        rstn = 1'b1;
        q1c.delete(); q1a.delete(); q3c.delete(); q3a.delete();
        r1 = rdv_cnt1; r3 = rdv_cnt3;
        s_write = 1'b1; s_addr = 15'h0900; s_burstcount = 4'd1;
        #1;
        check_eq("post_rst_write", m_write1, 1'b1);
        check_eq("post_rst_addr", m_addr1, 15'h0900);
        check_eq("post_rst_wait", s_waitrequest1, 1'b0);
        check_eq("post_rst_noread", m_read1, 1'b0);
        tick();
        s_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("post_rst_m_read", m_read1, 1'b0);
            check_eq("post_rst_rdv3", s_readdatavalid3, 1'b0);
            tick();
        end
        check_eq("post_rst_drop1", 128'(rdv_cnt1), 128'(r1));
        check_eq("post_rst_drop3", 128'(rdv_cnt3), 128'(r3));
        s_read = 1'b1; s_addr = 15'h0010; s_burstcount = 4'd1;
        #1;
        check_eq("post_rst_rd_wait", s_waitrequest1, 1'b0);
        tick();
        s_read = 1'b0;
        #1;
        check_eq("post_rst_rd_issue", m_read1, 1'b1);
        check_eq("post_rst_rd_addr", m_addr1, 15'h0010);
        tick();
        #1;
        check_eq("post_rst_rd_end", m_read1, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check_eq("post_rst_pulse1", 128'(rdv_cnt1), 128'(r1 + 1));
        check_eq("post_rst_pulse3", 128'(rdv_cnt3), 128'(r3 + 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
